// File: rtl/switch_allocator.sv
// Wormhole switch allocator for the 5-port crossbar: round-robin per output, lock from head to tail, pop via grant.
// Head flit transfers 1 cycle after allocation; out_ready low holds the lock without counting as a stall.
module switch_allocator #(
  parameter int STALL_LIMIT = 16,
  parameter int SEL_W       = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [4:0]           req_valid_i,
  input  logic [5*SEL_W-1:0]   req_dest_i,
  input  logic [4:0]           req_tail_i,
  input  logic [4:0]           out_ready_i,
  output logic [4:0]           grant_o,
  output logic [5*SEL_W-1:0]   cs_sel_o,
  output logic [4:0]           cs_enable_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o
);

  localparam int NP    = 5;
  localparam int CNT_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);
  localparam bit WD_EN = (STALL_LIMIT > 0);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q [NP];
  logic [SEL_W-1:0] owner_q [NP];
  logic [SEL_W-1:0] ptr_q   [NP];
  logic [CNT_W-1:0] cnt_q   [NP];
  logic             err_q;
  logic [1:0]       code_q;

  logic [SEL_W-1:0] dest   [NP];
  logic [SEL_W-1:0] winner [NP];
  logic [NP-1:0]    uturn, badport, legal, busy;
  logic [NP-1:0]    own_vld, xfer, rel_tail, rel_wd, win_vld;
  logic             err_set;
  logic [1:0]       err_cause;

  function automatic logic [SEL_W-1:0] inc_port(input logic [SEL_W-1:0] p);
    return (p == SEL_W'(NP - 1)) ? '0 : p + SEL_W'(1);
  endfunction

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      dest[p]    = req_dest_i[SEL_W*p +: SEL_W];
      uturn[p]   = req_valid_i[p] && (dest[p] == SEL_W'(p));
      badport[p] = req_valid_i[p] && (dest[p] > SEL_W'(NP - 1));
      legal[p]   = req_valid_i[p] && !uturn[p] && !badport[p];
    end
  end

  // An input that already holds any output may not compete for another one.
  always_comb begin
    busy = '0;
    for (int q = 0; q < NP; q++) begin
      if (state_q[q] == LOCKED) begin
        for (int p = 0; p < NP; p++) begin
          if (owner_q[q] == SEL_W'(p)) busy[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    own_vld  = '0;
    xfer     = '0;
    rel_tail = '0;
    rel_wd   = '0;
    win_vld  = '0;
    for (int q = 0; q < NP; q++) begin
      logic [SEL_W-1:0] own_dst;
      logic             own_tail;
      int               idx;
      own_dst   = '0;
      own_tail  = 1'b0;
      idx       = 0;
      winner[q] = '0;
      for (int p = 0; p < NP; p++) begin
        if (owner_q[q] == SEL_W'(p)) begin
          own_vld[q] = req_valid_i[p];
          own_dst    = dest[p];
          own_tail   = req_tail_i[p];
        end
      end
      if (state_q[q] == LOCKED) begin
        xfer[q]     = own_vld[q] && out_ready_i[q] && (own_dst == SEL_W'(q));
        rel_tail[q] = xfer[q] && own_tail;
        rel_wd[q]   = WD_EN && !own_vld[q] && (cnt_q[q] == STALL_LAST);
      end
      // Scan upward from the pointer; the first free legal requester wins.
      for (int k = 0; k < NP; k++) begin
        idx = (int'(ptr_q[q]) + k) % NP;
        if (!win_vld[q] && legal[idx] && !busy[idx] && (dest[idx] == SEL_W'(q))) begin
          win_vld[q] = 1'b1;
          winner[q]  = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_o  = '0;
    cs_sel_o = '0;
    for (int q = 0; q < NP; q++) begin
      if (state_q[q] == LOCKED) begin
        for (int p = 0; p < NP; p++) begin
          if (owner_q[q] == SEL_W'(p)) begin
            cs_sel_o[SEL_W*p +: SEL_W] = SEL_W'(q);
            if (xfer[q]) grant_o[p] = 1'b1;
          end
        end
      end
    end
  end

  assign cs_enable_o = grant_o;

  always_comb begin
    err_set   = (|uturn) || (|badport) || (|rel_wd);
    err_cause = (|uturn) ? 2'd1 : ((|badport) ? 2'd2 : 2'd3);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int q = 0; q < NP; q++) begin
        state_q[q] <= IDLE;
        owner_q[q] <= '0;
        ptr_q[q]   <= inc_port(SEL_W'(q));
        cnt_q[q]   <= '0;
      end
      err_q  <= 1'b0;
      code_q <= 2'd0;
    end else begin
      for (int q = 0; q < NP; q++) begin
        if (state_q[q] == IDLE) begin
          if (win_vld[q]) begin
            state_q[q] <= LOCKED;
            owner_q[q] <= winner[q];
            cnt_q[q]   <= '0;
          end
        end else begin
          if (rel_tail[q] || rel_wd[q]) begin
            state_q[q] <= IDLE;
            ptr_q[q]   <= inc_port(owner_q[q]);
            cnt_q[q]   <= '0;
          end else if (own_vld[q]) begin
            cnt_q[q] <= '0;
          end else if (WD_EN) begin
            cnt_q[q] <= cnt_q[q] + CNT_W'(1);
          end
        end
      end
      if (!err_q && err_set) begin
        err_q  <= 1'b1;
        code_q <= err_cause;
      end
    end
  end

  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic against a packet-level reference model.
module tb_switch_allocator;
  localparam int STALL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  vld = '0;
  logic [14:0] dst = '0;
  logic [4:0]  tail = '0;
  logic [4:0]  rdy = 5'b11111;
  logic [4:0]  grant;
  logic [14:0] cs_sel;
  logic [4:0]  cs_en;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  switch_allocator #(.STALL_LIMIT(STALL), .SEL_W(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(vld), .req_dest_i(dst),
    .req_tail_i(tail), .out_ready_i(rdy), .grant_o(grant), .cs_sel_o(cs_sel),
    .cs_enable_o(cs_en), .err_o(err), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  // Reference model state: per output lock/owner/pointer/stall, plus error latch.
  int m_lock[5], m_own[5], m_ptr[5], m_cnt[5];
  bit m_err;
  int m_code;
  // Input buffer emulation: flits left in the current packet and its destination.
  int rem[5], pdst[5];
  bit raw = 0;
  logic [4:0]  last_g, last_en;
  logic [14:0] last_sel;
  logic        last_err;
  logic [1:0]  last_code;

  function automatic int d(int p);
    return int'(dst[3*p +: 3]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 5; q++) begin
      m_lock[q] = 0; m_own[q] = 0; m_ptr[q] = (q + 1) % 5; m_cnt[q] = 0;
    end
    m_err = 0; m_code = 0;
  endtask

  task automatic model_step();
    bit busy[5];
    bit ut, bad, wd;
    ut = 0; bad = 0; wd = 0;
    for (int p = 0; p < 5; p++) busy[p] = 0;
    for (int q = 0; q < 5; q++) if (m_lock[q] != 0) busy[m_own[q]] = 1;
    for (int p = 0; p < 5; p++) begin
      if (vld[p] && d(p) == p) ut = 1;
      if (vld[p] && d(p) > 4) bad = 1;
    end
    for (int q = 0; q < 5; q++) begin
      if (m_lock[q] != 0) begin
        int p;
        p = m_own[q];
        if (vld[p] && rdy[q] && d(p) == q && tail[p]) begin
          m_lock[q] = 0; m_ptr[q] = (p + 1) % 5;
        end else if (vld[p]) begin
          m_cnt[q] = 0;
        end else begin
          m_cnt[q]++;
          if (STALL > 0 && m_cnt[q] == STALL) begin
            m_lock[q] = 0; m_ptr[q] = (p + 1) % 5; m_cnt[q] = 0; wd = 1;
          end
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          int c;
          c = (m_ptr[q] + k) % 5;
          if (vld[c] && d(c) == q && c != q && !busy[c]) begin
            m_lock[q] = 1; m_own[q] = c; m_cnt[q] = 0;
            break;
          end
        end
      end
    end
    if (!m_err && (ut || bad || wd)) begin
      m_err = 1;
      m_code = ut ? 1 : (bad ? 2 : 3);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 5; p++) begin
      vld[p] = (rem[p] > 0);
      dst[3*p +: 3] = 3'(pdst[p]);
      tail[p] = (rem[p] == 1);
    end
  endtask

  task automatic cyc();
    logic [4:0]  eg;
    logic [14:0] es;
    if (!raw) drive();
    @(negedge clk);
    eg = '0; es = '0;
    for (int q = 0; q < 5; q++) begin
      if (m_lock[q] != 0) begin
        int p;
        p = m_own[q];
        es[3*p +: 3] = 3'(q);
        if (vld[p] && rdy[q] && d(p) == q) eg[p] = 1'b1;
      end
    end
    last_g = grant; last_sel = cs_sel; last_en = cs_en; last_err = err; last_code = err_code;
    chk("grant", grant, eg);
    chk("cs_sel", cs_sel, es);
    chk("cs_enable", cs_en, eg);
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
    @(posedge clk);
    model_step();
    #1;
    for (int p = 0; p < 5; p++) if (last_g[p] && rem[p] > 0) rem[p]--;
  endtask

  task automatic do_reset();
    if (!raw) drive();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_sel", cs_sel, 0);
    chk("rst_enable", cs_en, 0);
    chk("rst_err", {err, err_code}, 0);
    model_reset();
    raw = 0;
    rdy = 5'b11111;
    for (int p = 0; p < 5; p++) begin rem[p] = 0; pdst[p] = 0; end
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int gc[5];
    int last_n, first_s;
    for (int p = 0; p < 5; p++) begin rem[p] = 0; pdst[p] = 0; end
    model_reset();

    // Single route W->E, 3 flits
    do_reset();
    rem[2] = 3; pdst[2] = 3;
    cyc(); chk("route_alloc_grant", last_g, 5'b00000);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("route_grant", last_g, 5'b00100);
      chk("route_sel_w", last_sel[8:6], 3'd3);
      chk("route_en", last_en, 5'b00100);
    end
    rem[0] = 1; pdst[0] = 3;
    cyc(); chk("route_e_idle_alloc", last_g, 5'b00000);
    chk("route_w_sel_clear", last_sel[8:6], 3'd0);
    cyc(); chk("route_e_reuse", last_g, 5'b00001);

    // Contention for L
    do_reset();
    for (int p = 0; p < 5; p++) gc[p] = -1;
    rem[0] = 1; pdst[0] = 4; rem[1] = 1; pdst[1] = 4; rem[3] = 1; pdst[3] = 4;
    for (int k = 0; k < 8; k++) begin
      cyc();
      for (int p = 0; p < 5; p++) if (last_g[p] && gc[p] < 0) gc[p] = k;
    end
    chk("cont_n_cycle", gc[0], 1);
    chk("cont_s_cycle", gc[1], 3);
    chk("cont_e_cycle", gc[3], 5);
    rem[0] = 1; pdst[0] = 4; rem[3] = 1; pdst[3] = 4;
    cyc(); cyc(); chk("cont_ptr_after", last_g, 5'b00001);
    cyc(); cyc(); chk("cont_e_last", last_g, 5'b01000);

    // Wormhole hold
    do_reset();
    rem[0] = 4; pdst[0] = 3;
    last_n = -1; first_s = -1;
    for (int k = 0; k < 11; k++) begin
      cyc();
      if (k == 0) begin rem[1] = 2; pdst[1] = 3; end
      if (last_g[0]) last_n = k;
      if (last_g[1] && first_s < 0) first_s = k;
    end
    chk("worm_n_tail", last_n, 4);
    chk("worm_s_first", first_s, 6);

    // Backpressure on E
    do_reset();
    rem[2] = 4; pdst[2] = 3;
    cyc(); cyc(); cyc();
    rdy[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_no_grant", last_g, 5'b00000);
      chk("bp_lock_held", last_sel[8:6], 3'd3);
      chk("bp_no_err", last_err, 1'b0);
    end
    rdy[3] = 1'b1;
    cyc(); chk("bp_resume", last_g, 5'b00100);
    cyc(); chk("bp_tail", last_g, 5'b00100);

    // Errors: U-turn first, then an out-of-range destination
    do_reset();
    rem[0] = 1; pdst[0] = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("uturn_no_grant", last_g, 5'b00000);
    end
    chk("uturn_err", {last_err, last_code}, 3'b101);
    rem[0] = 0; rem[1] = 1; pdst[1] = 6;
    cyc(); cyc();
    chk("bad_no_grant", last_g, 5'b00000);
    chk("bad_code_kept", last_code, 2'd1);

    // Watchdog release
    do_reset();
    rem[2] = 3; pdst[2] = 3;
    cyc(); cyc(); chk("wd_head", last_g, 5'b00100);
    rem[2] = 0;
    for (int k = 0; k < 4; k++) cyc();
    chk("wd_before", last_code, 2'd0);
    cyc();
    chk("wd_code", {last_err, last_code}, 3'b111);
    rem[0] = 1; pdst[0] = 3;
    cyc(); cyc(); chk("wd_e_free", last_g, 5'b00001);

    // Reset mid-packet, then immediate reallocation
    do_reset();
    rem[2] = 3; pdst[2] = 3;
    cyc(); cyc();
    do_reset();
    rem[0] = 1; pdst[0] = 3;
    cyc(); chk("post_rst_alloc", last_g, 5'b00000);
    cyc(); chk("post_rst_grant", last_g, 5'b00001);

    // Random traffic: legal destinations first, then with illegal ones mixed in
    do_reset();
    raw = 1;
    for (int k = 0; k < 600; k++) begin
      for (int p = 0; p < 5; p++) begin
        int dd;
        dd = $urandom_range(0, 4);
        if (k < 300 && dd == p) dd = (p + 1) % 5;
        if (k >= 300 && $urandom_range(0, 15) == 0) dd = $urandom_range(5, 7);
        vld[p] = ($urandom_range(0, 3) != 0);
        dst[3*p +: 3] = 3'(dd);
        tail[p] = ($urandom_range(0, 2) == 0);
        rdy[p] = ($urandom_range(0, 4) != 0);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Control stage directly upstream of the 5-port crossbar switch. Drives every per-input select and enable on the crossbar.
- Takes per-input flit requests from the input buffers (valid, destination port, tail marker). Arbitrates each output port round-robin.
- Holds each output allocated to one input from head flit to tail flit (wormhole). Pops the input buffers through a per-input grant.

Parameters:
- STALL_LIMIT, default 16: consecutive cycles a locked owner may present no flit before the lock is force-released. 0 disables the watchdog.
- SEL_W, default 3: width of a port code. Fixed at 3; port codes are N=0, S=1, W=2, E=3, L=4.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  5  bit p: input p presents a flit this cycle
- req_dest_i  in  15  bits [3p+2:3p]: destination port code for input p
- req_tail_i  in  5  bit p: the presented flit is a packet tail (a single-flit packet has head and tail set together)
- out_ready_i  in  5  bit q: downstream of output q accepts a flit this cycle
- grant_o  out  5  bit p: flit of input p is transferred this cycle; the buffer pops
- cs_sel_o  out  15  bits [3p+2:3p]: crossbar select for input p, equal to the locked output code
- cs_enable_o  out  5  bit p: crossbar enable for input p
- err_o  out  1  sticky error flag
- err_code_o  out  2  first error cause: 1 = U-turn, 2 = illegal destination (>4), 3 = watchdog release

Behaviour:
- Reset (async assert, sync release): all outputs are 0 and all outputs are IDLE. Each output q's round-robin pointer resets to (q+1) mod 5. err_o is cleared.
- Per-output FSM, two states:
  - IDLE: candidates are the inputs p with req_valid_i[p]=1 and req_dest(p)=q. The winner is the first candidate scanning from the pointer upward, mod 5. At the clock edge, owner[q] <= winner and the state goes to LOCKED. There is no transfer in the allocation cycle.
  - LOCKED: transfer(q) = req_valid_i[owner] & out_ready_i[q] & (req_dest(owner)==q). On transfer, grant_o[owner], cs_enable_o[owner] and the owner's cs_sel_o are driven combinationally in the same cycle.
  - A transfer with req_tail_i set moves the output to IDLE at the edge, with pointer <= owner+1 mod 5.
- Each input is in at most one lock at a time. An input that already owns an output is not a candidate elsewhere.
- Latency: a head flit arriving at an idle, free output transfers exactly 1 cycle after req_valid_i rises. Following flits transfer 1 per cycle while out_ready_i stays high.
- Single-flit packet (head and tail in the same flit): locks, transfers once, returns to IDLE. An output sustains 1 packet per 2 cycles.
- A tail transfer and a new request on the same output in the same cycle: the new request is arbitrated in the next cycle, using the updated pointer.
- cs_sel_o for an input with no lock is 0. cs_enable_o[p] is 0 whenever grant_o[p] is 0.
- Illegal requests never allocate and are never granted:
  - U-turn (dest == own port): sets err_o, err_code 1.
  - dest > 4: sets err_o, err_code 2.
  - Only the first error code is kept; it clears only on reset.
- Watchdog (STALL_LIMIT > 0):
  - Per-output counter increments each LOCKED cycle where req_valid_i[owner]=0, and resets on any owner-valid cycle.
  - out_ready_i low does not count as a stall.
  - When the counter reaches STALL_LIMIT: output goes to IDLE, pointer <= owner+1, err_code 3.
- Reset asserted mid-packet: all locks drop immediately and outputs go to 0. Upstream buffers are flushed by the same reset.

Test Plan:
- Single route: W requests E (dest=3) with a 3-flit packet, out_ready all 1.
  - Cycle 0: allocation, no grant.
  - Cycles 1-3: grant_o=5'b00100, cs_sel W=3, cs_enable W=1.
  - Cycle 4: E is IDLE again.
- Contention for L after reset (pointer for L = 0): N, S and E request L simultaneously with 1-flit packets.
  - Grants go N, then S, then E, each 2 cycles apart.
  - The L pointer ends at 4.
- Wormhole hold: N holds E for 4 flits while S requests E from cycle 1. S is not granted until the cycle after N's tail transfer plus 1 allocation cycle.
- Backpressure: out_ready_i[E]=0 for 5 cycles mid-packet (STALL_LIMIT=16). No grants during that window, lock held, no error; transfer resumes when ready returns to 1.
- Errors:
  - N requests dest=0: never granted, err_o=1, err_code=1.
  - A later dest=6 request: err_code stays 1.
- Watchdog and reset:
  - STALL_LIMIT=4: owner W drops valid after its head flit. After 4 cycles E is IDLE and err_code=3.
  - rst_n_i pulsed low mid-packet: all outputs are 0 asynchronously, and a new allocation works on the first cycle after release.
